// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target endpoint exposing an 8-entry byte register file
// through the usual pointer protocol (write pointer, then write or read data
// with auto-increment). Entries 0-3 are read/write and drive o_regs; entries
// 4-7 read back i_status. SCL is never stretched.
//
// Ports:
//   S_AXI_ACLK  system clock; bus pins are oversampled on it
//   rst         asynchronous active-high reset
//   scl         I2C clock (input only)
//   sda         I2C data, open-drain (drives 0 or z)
//   i_status    read-only entries 4-7, entry k at [8(k-4)+7 : 8(k-4)]
//   o_regs      read/write entries 0-3, entry k at [8k+7 : 8k]
//   o_wr_strobe one-cycle pulse when a byte is committed to entries 0-3
//   o_wr_index  entry index qualified by o_wr_strobe
//   o_busy      high from an address match until the next START or STOP
module i2c_target_regs #(
  parameter logic [6:0] TARGET_ADDR = 7'h42
) (
  input  logic        S_AXI_ACLK,
  input  logic        rst,
  input  logic        scl,
  inout  wire         sda,
  input  logic [31:0] i_status,
  output logic [31:0] o_regs,
  output logic        o_wr_strobe,
  output logic [1:0]  o_wr_index,
  output logic        o_busy
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned NUM_RW = 4;
  localparam int unsigned PTR_W  = 3;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned IDX_W  = 2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RX_ADDR,
    S_ACK_ADDR,
    S_RX_PTR,
    S_ACK_PTR,
    S_RX_DATA,
    S_ACK_DATA,
    S_TX_DATA,
    S_RX_MACK
  } state_e;

  // Pin synchronisers plus one history stage for edge detection.
  logic scl_meta_q, scl_sync_q, scl_hist_q;
  logic sda_meta_q, sda_sync_q, sda_hist_q;

  always_ff @(posedge S_AXI_ACLK or posedge rst) begin
    if (rst) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_hist_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_meta_q <= scl;
      scl_sync_q <= scl_meta_q;
      scl_hist_q <= scl_sync_q;
      sda_meta_q <= sda;
      sda_sync_q <= sda_meta_q;
      sda_hist_q <= sda_sync_q;
    end
  end

  // Bus events on the synchronised signals.
  logic scl_rise_c, scl_fall_c, start_c, stop_c;
  always_comb begin
    scl_rise_c = scl_sync_q & ~scl_hist_q;
    scl_fall_c = ~scl_sync_q & scl_hist_q;
    start_c    = scl_sync_q & scl_hist_q & sda_hist_q & ~sda_sync_q;
    stop_c     = scl_sync_q & scl_hist_q & ~sda_hist_q & sda_sync_q;
  end

  state_e                          state_q, state_d;
  logic [CNT_W-1:0]                bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]               shift_q, shift_d;
  logic [PTR_W-1:0]                ptr_q, ptr_d;
  logic [NUM_RW-1:0][BYTE_W-1:0]   regs_q, regs_d;
  logic                            wr_strobe_q, wr_strobe_d;
  logic [IDX_W-1:0]                wr_index_q, wr_index_d;
  logic                            busy_q, busy_d;
  logic                            sda_oe_q, sda_oe_d;
  logic                            mack_q, mack_d;

  // Entry addressed by the current pointer; status entries are sampled here
  // at byte-load time.
  logic [BYTE_W-1:0] rd_byte_c;
  always_comb begin
    if (ptr_q[PTR_W-1]) begin
      rd_byte_c = i_status[{ptr_q[IDX_W-1:0], 3'b000} +: BYTE_W];
    end else begin
      rd_byte_c = regs_q[ptr_q[IDX_W-1:0]];
    end
  end

  // A receive state takes a bit on each rising edge until 8 are in, and
  // finishes the byte on the following falling edge (start of the ACK slot).
  logic [BYTE_W-1:0] rx_byte_c;
  logic              rx_bit_c, rx_done_c;
  always_comb begin
    rx_byte_c = {shift_q[BYTE_W-2:0], sda_sync_q};
    rx_bit_c  = scl_rise_c && (bit_cnt_q != CNT_W'(BYTE_W));
    rx_done_c = scl_fall_c && (bit_cnt_q == CNT_W'(BYTE_W));
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    wr_index_d  = wr_index_q;
    busy_d      = busy_q;
    sda_oe_d    = sda_oe_q;
    mack_d      = mack_q;

    if (start_c) begin
      // START / repeated START wins over bit processing; pointer is kept.
      state_d   = S_RX_ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (stop_c) begin
      state_d  = S_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
        end

        S_RX_ADDR: begin
          if (rx_bit_c) begin
            shift_d   = rx_byte_c;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end else if (rx_done_c) begin
            if (shift_q[BYTE_W-1:1] == TARGET_ADDR) begin
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
              state_d  = S_ACK_ADDR;
            end else begin
              // Leaving sda released is the NACK.
              state_d = S_IDLE;
            end
          end
        end

        S_ACK_ADDR: begin
          if (scl_fall_c) begin
            bit_cnt_d = '0;
            if (shift_q[0]) begin
              // Read: first data bit goes out on the same falling edge.
              shift_d  = rd_byte_c;
              sda_oe_d = ~rd_byte_c[BYTE_W-1];
              state_d  = S_TX_DATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = S_RX_PTR;
            end
          end
        end

        S_RX_PTR: begin
          if (rx_bit_c) begin
            shift_d   = rx_byte_c;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end else if (rx_done_c) begin
            ptr_d    = shift_q[PTR_W-1:0];
            sda_oe_d = 1'b1;
            state_d  = S_ACK_PTR;
          end
        end

        S_ACK_PTR, S_ACK_DATA: begin
          if (scl_fall_c) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = S_RX_DATA;
          end
        end

        S_RX_DATA: begin
          if (rx_bit_c) begin
            shift_d   = rx_byte_c;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            // Commit on the 8th rising edge so o_regs/strobe land one clock later.
            if (bit_cnt_q == CNT_W'(BYTE_W - 1)) begin
              if (!ptr_q[PTR_W-1]) begin
                regs_d[ptr_q[IDX_W-1:0]] = rx_byte_c;
                wr_strobe_d              = 1'b1;
                wr_index_d               = ptr_q[IDX_W-1:0];
              end
              ptr_d = ptr_q + PTR_W'(1);
            end
          end else if (rx_done_c) begin
            sda_oe_d = 1'b1;
            state_d  = S_ACK_DATA;
          end
        end

        S_TX_DATA: begin
          if (scl_fall_c) begin
            if (bit_cnt_q == CNT_W'(BYTE_W - 1)) begin
              sda_oe_d = 1'b0;
              state_d  = S_RX_MACK;
            end else begin
              shift_d   = {shift_q[BYTE_W-2:0], 1'b0};
              sda_oe_d  = ~shift_q[BYTE_W-2];
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end

        S_RX_MACK: begin
          if (scl_rise_c) begin
            mack_d = sda_sync_q;
            ptr_d  = ptr_q + PTR_W'(1);
          end else if (scl_fall_c) begin
            if (!mack_q) begin
              // ptr_q already advanced on the rising edge.
              shift_d   = rd_byte_c;
              sda_oe_d  = ~rd_byte_c[BYTE_W-1];
              bit_cnt_d = '0;
              state_d   = S_TX_DATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = S_IDLE;
            end
          end
        end

        default: begin
          state_d  = S_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge S_AXI_ACLK or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      ptr_q       <= '0;
      regs_q      <= '0;
      wr_strobe_q <= 1'b0;
      wr_index_q  <= '0;
      busy_q      <= 1'b0;
      sda_oe_q    <= 1'b0;
      mack_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      regs_q      <= regs_d;
      wr_strobe_q <= wr_strobe_d;
      wr_index_q  <= wr_index_d;
      busy_q      <= busy_d;
      sda_oe_q    <= sda_oe_d;
      mack_q      <= mack_d;
    end
  end

  assign sda         = sda_oe_q ? 1'b0 : 1'bz;
  assign o_regs      = regs_q;
  assign o_wr_strobe = wr_strobe_q;
  assign o_wr_index  = wr_index_q;
  assign o_busy      = busy_q;

endmodule
